// File: rtl/fr_track_loop_sequencer.sv
// Frequency-tracking loop sequencer: averages phase-error windows, runs the PID
// start/done handshake, applies the clamped adjustment and tracks lock.
module fr_track_loop_sequencer #(
    parameter int ACC_LOG2   = 3,
    parameter int LOCK_TH    = 16,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int TIMEOUT    = 64,
    parameter int FREQ_INIT  = 100000,
    parameter int FREQ_MIN   = 90000,
    parameter int FREQ_MAX   = 110000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        phase_valid,
    input  logic [15:0] phase_diff,
    output logic        pid_start,
    output logic [15:0] pid_error,
    input  logic        pid_done,
    input  logic [31:0] pid_adjust,
    output logic [31:0] freq_word,
    output logic        freq_update,
    output logic        locked,
    output logic        busy,
    output logic        timeout_err
);

    localparam int ACC_W = 17 + ACC_LOG2;
    localparam int CNT_W = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam int WIN   = 1 << ACC_LOG2;
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int LCK_W = 8;

    localparam logic signed [33:0] FMIN_S = 34'(FREQ_MIN);
    localparam logic signed [33:0] FMAX_S = 34'(FREQ_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_APPLY = 3'd4
    } state_t;

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [TMR_W-1:0]          tmr_q;
    logic [LCK_W-1:0]          in_cnt_q;
    logic [LCK_W-1:0]          out_cnt_q;
    logic                      pid_start_q;
    logic [15:0]               pid_error_q;
    logic [31:0]               freq_word_q;
    logic                      freq_update_q;
    logic                      locked_q;
    logic                      busy_q;
    logic                      timeout_err_q;

    logic signed [ACC_W-1:0]   acc_d;
    logic signed [33:0]        sum_d;
    logic [31:0]               freq_d;
    logic [16:0]               err_abs_d;
    logic                      err_ok_d;
    logic [LCK_W-1:0]          in_cnt_d;
    logic [LCK_W-1:0]          out_cnt_d;

    function automatic logic [31:0] clamp_freq(input logic signed [33:0] s);
        if (s < FMIN_S) begin
            return FMIN_S[31:0];
        end else if (s > FMAX_S) begin
            return FMAX_S[31:0];
        end else begin
            return s[31:0];
        end
    endfunction

    function automatic logic [16:0] abs17(input logic [15:0] e);
        logic [16:0] ext;
        ext = {e[15], e};
        if (ext[16]) begin
            return 17'd0 - ext;
        end else begin
            return ext;
        end
    endfunction

    // Datapath helpers: running sum, clamped frequency, lock-counter next values
    always_comb begin
        acc_d     = acc_q + {{(ACC_W-16){phase_diff[15]}}, phase_diff};
        sum_d     = $signed({2'b00, freq_word_q}) + $signed({{2{pid_adjust[31]}}, pid_adjust});
        freq_d    = clamp_freq(sum_d);
        err_abs_d = abs17(pid_error_q);
        err_ok_d  = (err_abs_d <= 17'(LOCK_TH));
        in_cnt_d  = (in_cnt_q == {LCK_W{1'b1}}) ? in_cnt_q : in_cnt_q + 8'd1;
        out_cnt_d = (out_cnt_q == {LCK_W{1'b1}}) ? out_cnt_q : out_cnt_q + 8'd1;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            pid_start_q   <= 1'b0;
            pid_error_q   <= 16'd0;
            freq_word_q   <= 32'(FREQ_INIT);
            freq_update_q <= 1'b0;
            locked_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pid_start_q   <= 1'b0;
            freq_update_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (!enable) begin
                        state_q   <= S_IDLE;
                        locked_q  <= 1'b0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end else if (phase_valid) begin
                        if (cnt_q == CNT_W'(WIN - 1)) begin
                            // Floor mean: arithmetic shift of the full sum fits 16 bits
                            pid_error_q <= acc_d[ACC_LOG2 +: 16];
                            pid_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_REQ;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        state_q <= S_ACCUM;
                    end
                end
                S_REQ: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (pid_done) begin
                        freq_word_q   <= freq_d;
                        freq_update_q <= 1'b1;
                        state_q       <= S_APPLY;
                        if (err_ok_d) begin
                            in_cnt_q  <= in_cnt_d;
                            out_cnt_q <= '0;
                            if (in_cnt_d >= LCK_W'(LOCK_CNT)) begin
                                locked_q <= 1'b1;
                            end else begin
                                locked_q <= locked_q;
                            end
                        end else begin
                            out_cnt_q <= out_cnt_d;
                            in_cnt_q  <= '0;
                            if (out_cnt_d >= LCK_W'(UNLOCK_CNT)) begin
                                locked_q <= 1'b0;
                            end else begin
                                locked_q <= locked_q;
                            end
                        end
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        locked_q      <= 1'b0;
                        in_cnt_q      <= '0;
                        out_cnt_q     <= '0;
                        busy_q        <= 1'b0;
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        state_q       <= enable ? S_ACCUM : S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_APPLY: begin
                    busy_q <= 1'b0;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    if (enable) begin
                        state_q <= S_ACCUM;
                    end else begin
                        state_q   <= S_IDLE;
                        locked_q  <= 1'b0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pid_start   = pid_start_q;
    assign pid_error   = pid_error_q;
    assign freq_word   = freq_word_q;
    assign freq_update = freq_update_q;
    assign locked      = locked_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fr_track_loop_sequencer.sv
// Directed self-checking bench for fr_track_loop_sequencer.
module tb_fr_track_loop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        phase_valid;
    logic [15:0] phase_diff;
    logic        pid_done;
    logic [31:0] pid_adjust;
    logic        pid_start;
    logic [15:0] pid_error;
    logic [31:0] freq_word;
    logic        freq_update;
    logic        locked;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int fexp;

    always #5 clk = ~clk;

    fr_track_loop_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .phase_valid(phase_valid),
        .phase_diff (phase_diff),
        .pid_start  (pid_start),
        .pid_error  (pid_error),
        .pid_done   (pid_done),
        .pid_adjust (pid_adjust),
        .freq_word  (freq_word),
        .freq_update(freq_update),
        .locked     (locked),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Eight samples (first v0, then seven v); ends in the first WAIT cycle.
    task automatic do_window(input logic [15:0] v0, input logic [15:0] v,
                             input logic [15:0] exp_err, input string tag);
        phase_valid = 1'b1;
        phase_diff  = v0;
        step(1);
        phase_diff  = v;
        step(7);
        phase_valid = 1'b0;
        phase_diff  = 16'd0;
        chk({tag, "_start"}, 32'(pid_start), 32'd1);
        chk({tag, "_err"}, 32'(pid_error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step(1);
        chk({tag, "_start_off"}, 32'(pid_start), 32'd0);
    endtask

    // PID answers after 'delay' WAIT cycles; checks APPLY and the cycle after.
    task automatic do_pid(input int delay, input int adj, input int exp_freq,
                          input logic exp_lock, input string tag);
        step(delay);
        pid_done   = 1'b1;
        pid_adjust = 32'(adj);
        step(1);
        pid_done   = 1'b0;
        pid_adjust = 32'd0;
        chk({tag, "_upd"}, 32'(freq_update), 32'd1);
        chk({tag, "_freq"}, freq_word, 32'(exp_freq));
        chk({tag, "_lock"}, 32'(locked), 32'(exp_lock));
        step(1);
        chk({tag, "_upd_off"}, 32'(freq_update), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        phase_valid = 1'b0;
        phase_diff  = 16'd0;
        pid_done    = 1'b0;
        pid_adjust  = 32'd0;
        step(2);
        chk("rst_freq", freq_word, 32'd100000);
        chk("rst_start", 32'(pid_start), 32'd0);
        chk("rst_err", 32'(pid_error), 32'd0);
        chk("rst_lock", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);

        // Basic window and handshake
        rst    = 1'b0;
        enable = 1'b1;
        step(1);
        do_window(16'd40, 16'd40, 16'd40, "t1");
        do_pid(3, -25, 99975, 1'b0, "t1");

        // Floor rounding and most-negative mean
        do_window(16'hFFFF, 16'h0000, 16'hFFFF, "t2_floor");
        do_pid(1, 0, 99975, 1'b0, "t2_floor");
        do_window(16'h8000, 16'h8000, 16'h8000, "t2_min");
        do_pid(1, 0, 99975, 1'b0, "t2_min");

        // Clamping at both ends
        do_window(16'd100, 16'd100, 16'd100, "t3a");
        do_pid(2, 25, 100000, 1'b0, "t3a");
        do_window(16'd100, 16'd100, 16'd100, "t3_max");
        do_pid(2, 20000, 110000, 1'b0, "t3_max");
        do_window(16'd100, 16'd100, 16'd100, "t3_min");
        do_pid(2, -50000, 90000, 1'b0, "t3_min");

        // Lock acquisition, loss and count restart
        fexp = 90000;
        for (int i = 0; i < 4; i++) begin
            do_window(16'd10, 16'd10, 16'd10, "t4_good");
            fexp = fexp + 5;
            do_pid(1, 5, fexp, (i == 3), "t4_good");
        end
        for (int i = 0; i < 2; i++) begin
            do_window(16'd100, 16'd100, 16'd100, "t4_bad");
            fexp = fexp + 5;
            do_pid(1, 5, fexp, (i == 0), "t4_bad");
        end
        for (int i = 0; i < 3; i++) begin
            do_window(16'd10, 16'd10, 16'd10, "t4_pre");
            fexp = fexp + 5;
            do_pid(1, 5, fexp, 1'b0, "t4_pre");
        end
        do_window(16'hFF9C, 16'hFF9C, 16'hFF9C, "t4_brk");
        fexp = fexp + 5;
        do_pid(1, 5, fexp, 1'b0, "t4_brk");
        for (int i = 0; i < 4; i++) begin
            do_window(16'hFFF6, 16'hFFF6, 16'hFFF6, "t4_rst");
            fexp = fexp + 5;
            do_pid(1, 5, fexp, (i == 3), "t4_rst");
        end

        // Timeout, stray pid_done, done on the final timeout cycle
        do_window(16'd10, 16'd10, 16'd10, "t5");
        step(63);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        chk("t5_pre_tmo", 32'(timeout_err), 32'd0);
        step(1);
        chk("t5_tmo", 32'(timeout_err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_lock", 32'(locked), 32'd0);
        chk("t5_freq", freq_word, 32'(fexp));
        chk("t5_upd", 32'(freq_update), 32'd0);
        pid_done   = 1'b1;
        pid_adjust = 32'd1000;
        step(1);
        pid_done   = 1'b0;
        pid_adjust = 32'd0;
        chk("t5_stray_upd", 32'(freq_update), 32'd0);
        chk("t5_stray_freq", freq_word, 32'(fexp));
        do_window(16'd10, 16'd10, 16'd10, "t5_last");
        fexp = fexp + 5;
        do_pid(63, 5, fexp, 1'b0, "t5_last");
        chk("t5_sticky", 32'(timeout_err), 32'd1);

        // enable drop during WAIT, IDLE ignores samples, reset mid-WAIT
        do_window(16'd10, 16'd10, 16'd10, "t6");
        enable = 1'b0;
        fexp = fexp + 5;
        do_pid(2, 5, fexp, 1'b0, "t6");
        phase_valid = 1'b1;
        phase_diff  = 16'd10;
        step(10);
        phase_valid = 1'b0;
        chk("t6_idle_start", 32'(pid_start), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_freq", freq_word, 32'(fexp));
        enable = 1'b1;
        step(1);
        do_window(16'd20, 16'd20, 16'd20, "t6_rst");
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_freq", freq_word, 32'd100000);
        chk("t6_rst_err", 32'(pid_error), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_tmo", 32'(timeout_err), 32'd0);
        chk("t6_rst_lock", 32'(locked), 32'd0);
        chk("t6_rst_upd", 32'(freq_update), 32'd0);
        chk("t6_rst_start", 32'(pid_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
